shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
- Sequential unsigned shift-and-add multiply-accumulate. It computes product = multiplicand*multiplier + addend, which is the inverse operation of the team's sequential divider.
- With quotient, divisor and remainder as inputs, it reconstructs the dividend. This closes the loop in divider self-checks and provides a reusable MAC for the datapath.
- Start/busy/done handshake. One multiplier bit is processed per clock.

Parameters:
- WORD_LENGTH, 16, width of multiplicand, multiplier and addend. Product width is 2*WORD_LENGTH. Legal range is 2..32.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset. Sampled only on the rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- multiplicand  input  WORD_LENGTH  unsigned operand A, captured on accepted start.
- multiplier  input  WORD_LENGTH  unsigned operand B, captured on accepted start.
- addend  input  WORD_LENGTH  unsigned accumulate term, captured on accepted start.
- product  output  2*WORD_LENGTH  registered result; holds its value until the next completion or reset.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse when product updates.

Behaviour:
- Reset (reset==0 at an edge) forces:
  - state=IDLE
  - product=0, busy=0, done=0
  - internal operand, accumulator and counter registers=0
- Reset has priority over every other event, including mid-RUN and in DONE. The operation in progress is discarded and no done pulse follows.
- State machine has three states: IDLE, RUN, DONE.
  - IDLE: on start==1, go to RUN and load the working registers:
    - mcand = multiplicand, zero-extended to 2*WORD_LENGTH
    - mplier = multiplier
    - acc = addend, zero-extended
    - count = 0
  - IDLE: on start==0, stay in IDLE.
  - RUN: each cycle:
    - if mplier[0]==1, acc = acc + mcand
    - mcand shifts left by 1
    - mplier shifts right by 1
    - count increments
    - when count == WORD_LENGTH-1 at the edge, go to DONE
    - RUN therefore lasts exactly WORD_LENGTH cycles.
  - DONE: product <= acc, done=1 for this single cycle, busy=1, then IDLE unconditionally.
- Latency:
  - start is accepted at edge T0.
  - done is high in the cycle following edge T0+WORD_LENGTH+1.
  - product is valid from that same edge.
  - Throughput is one operation per WORD_LENGTH+2 cycles.
- start in RUN or DONE is ignored and not queued. Operand changes after acceptance have no effect.
- start held high continuously: a new operation is accepted on the first IDLE cycle after done.
- Width: acc is 2*WORD_LENGTH bits, with no overflow possible.
  - max = (2^W-1)^2 + (2^W-1) = 2^2W - 2^W < 2^2W.
  - No saturation or overflow flag exists.
- Zero operands still take the full latency. There is no early termination.
- Outputs are registered only, with no combinational path from inputs to outputs.

Decomposition:
- Package mult_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t
  - function clog2-based COUNT_WIDTH = $clog2(WORD_LENGTH)
- Optional sub-module bit_counter holds the RUN counter. It has clk, reset, clear, enable inputs, a terminal-count output, and is parameterized by WORD_LENGTH.
- Datapath and FSM stay in the top module.

Test Plan:
- Divider inverse: multiplicand=89, multiplier=2, addend=68, start pulse:
  - product=246 (0x000000F6)
  - done one cycle exactly 17 cycles after the accept edge
  - busy high 17 cycles
- Max values, all operands 16'hFFFF -> product=32'hFFFF0000, no wrap.
- Zeros, multiplicand=0, multiplier=0, addend=0 -> product=0 after full latency. Then 0x1234*1+0 -> product=0x00001234.
- Busy-ignore:
  - 100*3+7 accepted; start re-pulsed mid-RUN with 5*5+0 -> single done, product=307.
  - Next start is accepted only after return to IDLE, giving 25.
- Reset mid-op:
  - start 1000*1000+0; reset low at RUN cycle 8 -> product=0, busy=0, no done pulse.
  - After release, 1000*1000 -> product=1000000 (0x000F4240).
- Back-to-back: start held high for 3 operations -> done pulses spaced exactly 18 cycles apart, with each product matching its operands.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the shift-add multiply-accumulate
// Purpose: FSM state encoding and the counter-width helper used by
//          shift_add_multiplier and bit_counter.
// Ports:   none (package).
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Width of the RUN counter: enough bits to hold 0..word_length-1.
  function automatic int count_width(input int word_length);
    return (word_length < 2) ? 1 : $clog2(word_length);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - RUN-phase bit counter with terminal-count flag
// Purpose: counts processed multiplier bits; terminal is high while the
//          count equals WORD_LENGTH-1 (the last bit of the operation).
// Ports:   clk, reset (sync, active-low), clear (restart at 0),
//          enable (advance by one), terminal (last-bit flag).
module bit_counter
  import mult_pkg::*;
#(
  parameter int WORD_LENGTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = count_width(WORD_LENGTH);
  localparam logic [CW-1:0] LAST = CW'(WORD_LENGTH - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned multiply-accumulate, one bit per clock
// Purpose: product = multiplicand * multiplier + addend using shift-and-add.
// Ports:   clk, reset (sync, active-low), start (sampled in IDLE),
//          multiplicand / multiplier / addend (captured on accepted start),
//          product (registered, held until next completion or reset),
//          busy (high in RUN and DONE), done (one-cycle pulse on product update).
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WORD_LENGTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WORD_LENGTH-1:0]   multiplicand,
  input  logic [WORD_LENGTH-1:0]   multiplier,
  input  logic [WORD_LENGTH-1:0]   addend,
  output logic [2*WORD_LENGTH-1:0] product,
  output logic                     busy,
  output logic                     done
);

  localparam int PW = 2 * WORD_LENGTH;

  mult_state_t state, next_state;

  logic [PW-1:0]          mcand;
  logic [WORD_LENGTH-1:0] mplier;
  logic [PW-1:0]          acc;

  logic load, step, finish, last_bit;

  bit_counter #(.WORD_LENGTH(WORD_LENGTH)) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (load),
    .enable   (step),
    .terminal (last_bit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Per-state control strobes
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE:    load   = start;
      RUN:     step   = 1'b1;
      DONE:    finish = 1'b1;
      default: ;
    endcase
  end

  // Datapath and registered outputs. acc is double width, so the
  // worst case (2^W-1)^2 + (2^W-1) always fits and no overflow handling exists.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (load) begin
        mcand  <= {{WORD_LENGTH{1'b0}}, multiplicand};
        mplier <= multiplier;
        acc    <= {{WORD_LENGTH{1'b0}}, addend};
      end else if (step) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      if (finish) begin
        product <= acc;
      end
      done <= finish;
      // Registered from next_state so busy covers exactly the RUN and DONE cycles.
      busy <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic [W-1:0]  addend;
  logic [2*W-1:0] product;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.WORD_LENGTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic [2*W-1:0] exp;
    string          name;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Launch one operation from IDLE and check result, done latency and busy length.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [2*W-1:0] exp,
                       input string nm);
    int k;
    int bcnt;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    addend       = c;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    bcnt = 0;
    while (!done && k < 100) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      k++;
    end
    chk({nm, "_latency"}, k, W + 1);
    chk({nm, "_product"}, product, exp);
    chk({nm, "_busy_cycles"}, bcnt, W + 1);
  endtask

  vec_t vecs[7];

  initial begin
    int dcount;
    int cyc;
    int nops;
    int dcyc[3];
    logic [W-1:0]   ba[3];
    logic [W-1:0]   bb[3];
    logic [W-1:0]   bc[3];
    logic [2*W-1:0] be[3];
    logic [2*W-1:0] got;

    vecs[0] = '{16'd89,     16'd2,      16'd68,     32'd246,        "div_inverse"};
    vecs[1] = '{16'hFFFF,   16'hFFFF,   16'hFFFF,   32'hFFFF0000,   "max"};
    vecs[2] = '{16'd0,      16'd0,      16'd0,      32'd0,          "zeros"};
    vecs[3] = '{16'h1234,   16'd1,      16'd0,      32'h00001234,   "times_one"};
    vecs[4] = '{16'd12345,  16'd6789,   16'd111,    32'd83810316,   "mixed"};
    vecs[5] = '{16'd3,      16'hFFFF,   16'd0,      32'd196605,     "mplier_max"};
    vecs[6] = '{16'd1,      16'd1,      16'd1,      32'd2,          "ones"};

    reset = 1'b0;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    addend = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_product", product, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp, vecs[i].name);
    end

    // start re-pulsed mid-RUN must be ignored
    @(negedge clk);
    multiplicand = 16'd100;
    multiplier   = 16'd3;
    addend       = 16'd7;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    multiplicand = 16'd5;
    multiplier   = 16'd5;
    addend       = 16'd0;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcount = 0;
    got = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dcount++;
        got = product;
      end
    end
    chk("ignore_done_count", dcount, 1);
    chk("ignore_product", got, 307);
    chk("ignore_idle_after", busy, 0);
    do_op(16'd5, 16'd5, 16'd0, 32'd25, "after_ignore");

    // Reset during RUN discards the operation
    @(negedge clk);
    multiplicand = 16'd1000;
    multiplier   = 16'd1000;
    addend       = 16'd0;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_product", product, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    dcount = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    chk("midreset_no_done", dcount, 0);
    do_op(16'd1000, 16'd1000, 16'd0, 32'h000F4240, "after_reset");

    // start held high: three operations back to back
    ba[0] = 16'd7;     bb[0] = 16'd9;   bc[0] = 16'd3;  be[0] = 32'd66;
    ba[1] = 16'd200;   bb[1] = 16'd300; bc[1] = 16'd5;  be[1] = 32'd60005;
    ba[2] = 16'hFFFF;  bb[2] = 16'd2;   bc[2] = 16'd1;  be[2] = 32'd131071;
    @(negedge clk);
    multiplicand = ba[0];
    multiplier   = bb[0];
    addend       = bc[0];
    start        = 1'b1;
    nops = 0;
    cyc = 0;
    while (nops < 3 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        chk($sformatf("b2b_product_%0d", nops), product, be[nops]);
        dcyc[nops] = cyc;
        nops++;
        if (nops < 3) begin
          multiplicand = ba[nops];
          multiplier   = bb[nops];
          addend       = bc[nops];
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_done_count", nops, 3);
    if (nops == 3) begin
      chk("b2b_spacing_1", dcyc[1] - dcyc[0], W + 2);
      chk("b2b_spacing_2", dcyc[2] - dcyc[1], W + 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
